// File: rtl/uart_tx_param_if.sv
// uart_tx_param write-side bundle: producer strobes trmt/tx_data,
// transmitter returns fifo_full, fifo_count and the ovf drop pulse.
interface uart_tx_param_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                 trmt;
  logic [DATA_BITS-1:0] tx_data;
  logic                 fifo_full;
  logic [CW-1:0]        fifo_count;
  logic                 ovf;

  modport master (
    output trmt, tx_data,
    input  fifo_full, fifo_count, ovf
  );

  modport slave (
    input  trmt, tx_data,
    output fifo_full, fifo_count, ovf
  );
endinterface

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with TX FIFO, LSB first.
// Ports: clk, rst (sync, high), wr (trmt/tx_data/fifo status), tx, tx_done, busy.
module uart_tx_param #(
  parameter int DATA_BITS  = 8,
  parameter int BAUD_DIV   = 2604,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_param_if.slave    wr,
  output logic              tx,
  output logic              tx_done,
  output logic              busy
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int CNTW = $clog2(BAUD_DIV);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (BAUD_DIV < 2) begin : g_bad_baud
    $error("uart_tx_param: BAUD_DIV must be >= 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo
    $error("uart_tx_param: FIFO_DEPTH must be a power of 2 in 2..64");
  end

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP
  } state_t;

  state_t state_q, state_d;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wp_q, rp_q;
  logic [CW-1:0]        cnt_q;
  logic                 full;
  logic                 push, pop;
  logic                 ovf_q;

  logic [CNTW-1:0]      baud_q;
  logic [3:0]           idx_q;
  logic [DATA_BITS-1:0] sh_q;
  logic                 par_q;
  logic                 tx_q, tx_d;
  logic                 bit_end, last_data, last_stop;

  // Full is taken from the registered count, so a pop in the
  // same cycle does not make room for a concurrent write.
  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign push    = wr.trmt && !full;

  assign bit_end   = (baud_q == CNTW'(BAUD_DIV - 1));
  assign last_data = (idx_q == 4'(DATA_BITS - 1));
  assign last_stop = (idx_q == 4'(STOP_BITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) begin
        mem[wp_q] <= wr.tx_data;
        wp_q      <= wp_q + 1'b1;
      end
      if (pop) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      ovf_q <= wr.trmt && full;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE:
        if (cnt_q != '0) begin
          pop     = 1'b1;
          state_d = START;
        end
      START:
        if (bit_end) state_d = DATA;
      DATA:
        if (bit_end && last_data)
          state_d = (PARITY != 0) ? PAR : STOP;
      PAR:
        if (bit_end) state_d = STOP;
      STOP:
        // Chain straight into the next start bit when work is queued.
        if (bit_end && last_stop) begin
          if (cnt_q != '0) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_q[0];
      PAR:     tx_d = par_q;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_q <= '0;
      idx_q  <= '0;
      sh_q   <= '0;
      par_q  <= 1'b0;
    end else if (pop) begin
      sh_q   <= mem[rp_q];
      par_q  <= (^mem[rp_q]) ^ (PARITY == 2);
      baud_q <= '0;
      idx_q  <= '0;
    end else if (state_q != IDLE) begin
      if (bit_end) begin
        baud_q <= '0;
        if (state_q == DATA) begin
          sh_q  <= sh_q >> 1;
          idx_q <= last_data ? 4'd0 : idx_q + 4'd1;
        end else if (state_q == STOP) begin
          idx_q <= idx_q + 4'd1;
        end
      end else begin
        baud_q <= baud_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) tx_q <= 1'b1;
    else     tx_q <= tx_d;
  end

  assign tx            = tx_q;
  assign busy          = (state_q != IDLE);
  assign tx_done       = (state_q == IDLE) && (cnt_q == '0);
  assign wr.fifo_full  = full;
  assign wr.fifo_count = cnt_q;
  assign wr.ovf        = ovf_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Testbench for uart_tx_param: four configurations, a shared scoreboard
// queue and one line monitor per instance decoding frames off tx.
module tb_uart_tx_param;

  typedef struct {
    int k;
    int data;
    int par;
    bit b2b;
    bit abrt;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       trm [4];
  logic [8:0] dat [4];
  logic [3:0] txv, donev, busyv;
  int         cyc;
  int         checks;
  int         failures;
  exp_t       q[$];

  int bd [4] = '{16, 16, 16, 4};
  int db [4] = '{8, 8, 8, 7};
  int pr [4] = '{0, 1, 2, 0};
  int sb [4] = '{1, 2, 2, 1};

  uart_tx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) w0 ();
  uart_tx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) w1 ();
  uart_tx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) w2 ();
  uart_tx_param_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) w3 ();

  assign w0.trmt = trm[0];
  assign w1.trmt = trm[1];
  assign w2.trmt = trm[2];
  assign w3.trmt = trm[3];
  assign w0.tx_data = dat[0][7:0];
  assign w1.tx_data = dat[1][7:0];
  assign w2.tx_data = dat[2][7:0];
  assign w3.tx_data = dat[3][6:0];

  uart_tx_param #(
    .DATA_BITS(8), .BAUD_DIV(16), .PARITY(0),
    .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u0 (
    .clk(clk), .rst(rst), .wr(w0),
    .tx(txv[0]), .tx_done(donev[0]), .busy(busyv[0])
  );

  uart_tx_param #(
    .DATA_BITS(8), .BAUD_DIV(16), .PARITY(1),
    .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u1 (
    .clk(clk), .rst(rst), .wr(w1),
    .tx(txv[1]), .tx_done(donev[1]), .busy(busyv[1])
  );

  uart_tx_param #(
    .DATA_BITS(8), .BAUD_DIV(16), .PARITY(2),
    .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u2 (
    .clk(clk), .rst(rst), .wr(w2),
    .tx(txv[2]), .tx_done(donev[2]), .busy(busyv[2])
  );

  uart_tx_param #(
    .DATA_BITS(7), .BAUD_DIV(4), .PARITY(0),
    .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u3 (
    .clk(clk), .rst(rst), .wr(w3),
    .tx(txv[3]), .tx_done(donev[3]), .busy(busyv[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d cyc=%0d", nm, act, expv, cyc);
    end
  endtask

  task automatic add(input int k, input int d, input int p,
                     input bit b2b, input bit abrt);
    exp_t e;
    e.k    = k;
    e.data = d;
    e.par  = p;
    e.b2b  = b2b;
    e.abrt = abrt;
    q.push_back(e);
  endtask

  task automatic mon(input int k);
    exp_t e;
    int   bits [16];
    int   nb;
    int   t0;
    int   last_end;
    bit   ok;
    bit   ab;
    last_end = -10;
    forever begin
      @(negedge clk);
      if (txv[k] === 1'b0 && !rst) begin
        t0 = cyc;
        if (q.size() == 0 || q[0].k != k) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame dut=%0d got=start exp=idle cyc=%0d",
                   k, cyc);
          while (txv[k] === 1'b0) @(negedge clk);
        end else begin
          e = q.pop_front();
          if (e.b2b) chk($sformatf("gap_dut%0d", k), t0 - last_end, 1);
          bits[0] = 0;
          nb = 1;
          for (int i = 0; i < db[k]; i++) begin
            bits[nb] = (e.data >> i) & 1;
            nb++;
          end
          if (pr[k] != 0) begin
            bits[nb] = e.par;
            nb++;
          end
          for (int i = 0; i < sb[k]; i++) begin
            bits[nb] = 1;
            nb++;
          end
          ab = 1'b0;
          for (int i = 0; i < nb && !ab; i++) begin
            ok = 1'b1;
            for (int c = 0; c < bd[k]; c++) begin
              if (c != 0 || i != 0) @(negedge clk);
              if (rst) begin
                ab = 1'b1;
                break;
              end
              if (txv[k] !== 1'(bits[i])) ok = 1'b0;
            end
            if (!ab && !e.abrt)
              chk($sformatf("bit_dut%0d_d%0h_b%0d", k, e.data, i),
                  int'(ok), 1);
          end
          if (e.abrt) begin
            chk("abort_by_reset", int'(ab), 1);
            while (rst) @(negedge clk);
          end else if (!ab) begin
            last_end = cyc;
            chk($sformatf("frame_len_dut%0d", k), cyc - t0 + 1,
                (1 + db[k] + (pr[k] != 0 ? 1 : 0) + sb[k]) * bd[k]);
          end
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      automatic int kk = k;
      fork
        mon(kk);
      join_none
    end
  end

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (!(q.size() == 0 && donev[k] === 1'b1 && txv[k] === 1'b1)
           && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk($sformatf("idle_timeout_dut%0d", k), n, 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_tx"}, int'(txv[0]), 1);
    chk({tag, "_done"}, int'(donev[0]), 1);
    chk({tag, "_busy"}, int'(busyv[0]), 0);
    chk({tag, "_count"}, int'(w0.fifo_count), 0);
    chk({tag, "_full"}, int'(w0.fifo_full), 0);
    chk({tag, "_ovf"}, int'(w0.ovf), 0);
  endtask

  initial begin
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog got=running exp=finished cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    for (int k = 0; k < 4; k++) begin
      trm[k] = 1'b0;
      dat[k] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_state("rst0");
    chk("rst0_done_dut3", int'(donev[3]), 1);

    // 8N1 latency and frame timing, 0xA5
    @(negedge clk);
    trm[0] = 1'b1;
    dat[0] = 9'h0A5;
    add(0, 'hA5, 0, 1'b0, 1'b0);
    @(negedge clk);
    trm[0] = 1'b0;
    chk("lat_count_n", int'(w0.fifo_count), 1);
    chk("lat_done_n", int'(donev[0]), 0);
    @(negedge clk);
    chk("lat_busy_n1", int'(busyv[0]), 1);
    chk("lat_count_n1", int'(w0.fifo_count), 0);
    chk("lat_tx_n1", int'(txv[0]), 1);
    @(negedge clk);
    chk("lat_tx_n2", int'(txv[0]), 0);
    repeat (158) @(negedge clk);
    chk("end_busy_n160", int'(busyv[0]), 1);
    chk("end_done_n160", int'(donev[0]), 0);
    @(negedge clk);
    chk("end_done_n161", int'(donev[0]), 1);
    chk("end_busy_n161", int'(busyv[0]), 0);
    wait_idle(0);

    // 8E2: 0x07 has three ones, even parity bit 1
    @(negedge clk);
    trm[1] = 1'b1;
    dat[1] = 9'h007;
    add(1, 'h07, 1, 1'b0, 1'b0);
    @(negedge clk);
    trm[1] = 1'b0;
    wait_idle(1);

    // 8O2: odd parity bit 0
    @(negedge clk);
    trm[2] = 1'b1;
    dat[2] = 9'h007;
    add(2, 'h07, 0, 1'b0, 1'b0);
    @(negedge clk);
    trm[2] = 1'b0;
    wait_idle(2);

    // 7N1, BAUD_DIV=4: 0x55 -> 1,0,1,0,1,0,1
    @(negedge clk);
    trm[3] = 1'b1;
    dat[3] = 9'h055;
    add(3, 'h55, 0, 1'b0, 1'b0);
    @(negedge clk);
    trm[3] = 1'b0;
    wait_idle(3);

    // Overflow: six consecutive writes, the sixth is dropped
    @(negedge clk);
    trm[0] = 1'b1;
    dat[0] = 9'h001;
    add(0, 1, 0, 1'b0, 1'b0);
    for (int i = 2; i <= 6; i++) begin
      @(negedge clk);
      if (i == 5) chk("ovf_full_c4", int'(w0.fifo_full), 0);
      if (i == 6) begin
        chk("ovf_full_c5", int'(w0.fifo_full), 1);
        chk("ovf_count_c5", int'(w0.fifo_count), 4);
        chk("ovf_pulse_c5", int'(w0.ovf), 0);
      end
      dat[0] = 9'(i);
      if (i <= 5) add(0, i, 0, 1'b1, 1'b0);
    end
    @(negedge clk);
    trm[0] = 1'b0;
    chk("ovf_pulse_c6", int'(w0.ovf), 1);
    chk("ovf_count_c6", int'(w0.fifo_count), 4);
    @(negedge clk);
    chk("ovf_pulse_c7", int'(w0.ovf), 0);
    wait_idle(0);

    // Writes landing on the IDLE pop and on the STOP-end pop
    @(negedge clk);
    trm[0] = 1'b1;
    dat[0] = 9'h011;
    add(0, 'h11, 0, 1'b0, 1'b0);
    @(negedge clk);
    dat[0] = 9'h022;
    add(0, 'h22, 0, 1'b1, 1'b0);
    chk("pp_count_n", int'(w0.fifo_count), 1);
    @(negedge clk);
    trm[0] = 1'b0;
    chk("pp_count_n1", int'(w0.fifo_count), 1);
    repeat (159) @(negedge clk);
    chk("pp_count_n160", int'(w0.fifo_count), 1);
    trm[0] = 1'b1;
    dat[0] = 9'h033;
    add(0, 'h33, 0, 1'b1, 1'b0);
    @(negedge clk);
    trm[0] = 1'b0;
    chk("pp_count_n161", int'(w0.fifo_count), 1);
    chk("pp_busy_n161", int'(busyv[0]), 1);
    wait_idle(0);

    // Reset mid-frame: 0x5A aborted, queued 0x3C flushed
    @(negedge clk);
    trm[0] = 1'b1;
    dat[0] = 9'h05A;
    add(0, 'h5A, 0, 1'b0, 1'b1);
    @(negedge clk);
    dat[0] = 9'h03C;
    @(negedge clk);
    trm[0] = 1'b0;
    repeat (40) @(negedge clk);
    chk("mid_busy", int'(busyv[0]), 1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_state("rst1");
    repeat (60) @(negedge clk);
    chk("post_rst_tx", int'(txv[0]), 1);
    chk("post_rst_done", int'(donev[0]), 1);
    chk("scoreboard_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter for the segway serial links; it replaces the fixed 8N1 transmitter. It adds configurable data width, parity, stop-bit count and baud divisor. A small TX FIFO lets firmware or telemetry logic queue bytes, which are sent back-to-back with no inter-frame gap. The serial output is a single registered line, idle high, LSB first.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9
BAUD_DIV, 2604, clocks per bit period; legal >= 2
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame; legal 1 or 2
FIFO_DEPTH, 4, TX FIFO entries; power of 2, legal 2..64

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is synchronous and active-high
trmt  in  1  one-clock write strobe; pushes tx_data into FIFO
tx_data  in  DATA_BITS  word to queue, sampled when trmt=1
tx  out  1  serial line, registered, idle 1
tx_done  out  1  1 when FSM is IDLE and FIFO is empty
busy  out  1  1 while a frame is on the line (FSM not IDLE)
fifo_full  out  1  FIFO count == FIFO_DEPTH
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries queued, excluding the frame in flight
ovf  out  1  one-clock pulse when trmt is dropped because FIFO is full

Behaviour:
- Reset (rst=1 at posedge): tx=1, tx_done=1, busy=0, fifo_full=0, fifo_count=0, ovf=0. FIFO pointers cleared, FSM to IDLE, baud counter 0.
- Reset mid-frame: the frame is aborted and the FIFO is flushed. tx=1 from the next clock.
- Push: trmt && !fifo_full writes tx_data. trmt && fifo_full drops the word and sets ovf=1 for exactly the next cycle.
- fifo_full is evaluated on the registered count. A trmt in the same cycle as a pop while full is still dropped.
- Simultaneous push and pop (not full): count is unchanged and data order is preserved.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: if fifo_count != 0, pop the head into the shift register and go to START.
- START: tx=0 for BAUD_DIV clocks, then DATA.
- DATA: send DATA_BITS bits LSB first, each for BAUD_DIV clocks. Then go to PARITY if PARITY != 0, else STOP.
- PARITY: even parity bit = XOR of data bits; odd parity bit = its inverse. Held for BAUD_DIV clocks.
- STOP: tx=1 for STOP_BITS*BAUD_DIV clocks.
  - On the last clock of STOP, if the FIFO is non-empty, pop and go directly to START, giving zero idle gap between frames.
  - Otherwise go to IDLE.
- Baud counter runs 0..BAUD_DIV-1 only outside IDLE. It wraps at each bit boundary, so every bit lasts exactly BAUD_DIV clocks.
- Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * BAUD_DIV clocks.
- Latency: trmt sampled at edge N with an idle, empty block gives fifo_count=1 after N, the pop at N+1, and tx=0 after N+2. tx_done falls after edge N.
- tx_done = (state==IDLE) && (fifo_count==0). It rises the cycle after the final stop bit ends, when the FIFO is empty.
- busy is high from the first START cycle through the last STOP cycle.
- Illegal parameter values raise an elaboration-time $error.

Test Plan:
- Reset: hold rst 3 clocks, including once mid-frame -> tx=1, tx_done=1, busy=0, fifo_count=0, ovf=0 on the next clock; a previously queued 0x3C is never transmitted.
- 8N1, BAUD_DIV=16: trmt with 0xA5 -> tx=0 two clocks later; then bits 1,0,1,0,0,1,0,1 at 16 clocks each; stop=1; frame 160 clocks; tx_done=1 the clock after.
- Parity/stop, BAUD_DIV=16, STOP_BITS=2: 0x07 with PARITY=1 -> parity bit 1; PARITY=2 -> parity bit 0; frame 192 clocks with tx high for the last 32.
- FIFO overflow, FIFO_DEPTH=4: trmt on 6 consecutive clocks with 0x01..0x06 -> fifo_full at clock 5; 0x06 dropped with a single-cycle ovf pulse; 0x01..0x05 sent back-to-back with no idle clock between the stop and start bits.
- Width, DATA_BITS=7, PARITY=0, BAUD_DIV=4: tx_data=0x55 -> start, then 1,0,1,0,1,0,1, then stop; frame 36 clocks.
- Push during pop: queue 2 words, then trmt on the exact IDLE/STOP-end pop cycle -> fifo_count unchanged that cycle; all 3 words emitted in order.
